// File: rtl/framebuffer_arbiter.sv
// Framebuffer port arbiter: VGA line fetch bursts win, host writes fill gaps.
// Fetched pixels stream out with their in-line index two cycles after issue.
//
// Ports:
//   buffer_clock, reset        clock, async active-high reset
//   frame_start, line_req      sync pulses: rewind frame / fetch next line
//   host_req/addr/data, ack    level request, single-cycle ack on issue
//   mem_en/we/addr/wdata/rdata external memory port, rdata 1 cycle after read
//   vid_valid/data/index       fetched pixel stream
//   overrun                    line_req seen while a fetch already pending
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 12,
  parameter int LINE_PIXELS = 640,
  parameter int LINES       = 480
) (
  input  logic                  buffer_clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_req,
  input  logic                  host_req,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic [9:0]            vid_index,
  output logic                  overrun
);

  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam int LW = $clog2(LINES + 1);

  localparam logic [CW-1:0] CNT_END =
    CW'(LINE_PIXELS);
  localparam logic [LW-1:0] LINES_MAX =
    LW'(LINES);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP =
    ADDR_WIDTH'(LINE_PIXELS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [LW-1:0]         lines_done_q, lines_done_d;
  logic                  pending_q, pending_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  drain_q, drain_d;
  logic                  ignore_q, ignore_d;

  logic                  host_ack_q, host_ack_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [9:0]            idx_q, idx_d;
  logic                  overrun_q, overrun_d;

  logic                  rd_v_q;
  logic [9:0]            rd_idx_q;
  logic                  vid_valid_q;
  logic [DATA_WIDTH-1:0] vid_data_q;
  logic [9:0]            vid_index_q;

  logic                  accept;

  assign accept = line_req &&
                  (lines_done_q < LINES_MAX);

  always_comb begin
    state_d      = state_q;
    fetch_ptr_d  = fetch_ptr_q;
    lines_done_d = lines_done_q;
    pending_d    = pending_q;
    count_d      = count_q;
    drain_d      = drain_q;
    ignore_d     = 1'b0;
    host_ack_d   = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    idx_d        = idx_q;
    overrun_d    = line_req & pending_q;

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          // Issue pixel 0 on entry so the first
          // strobe shows up with the state change.
          state_d    = S_FETCH;
          pending_d  = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = fetch_ptr_q;
          idx_d      = '0;
          count_d    = CW'(1);
        end else if (host_req && !ignore_q &&
                     !accept) begin
          // A line_req this cycle keeps the port
          // free so the fetch goes first.
          state_d     = S_WRITE;
          host_ack_d  = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = host_addr;
          mem_wdata_d = host_data;
        end
      end
      S_FETCH: begin
        if (count_q == CNT_END) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = fetch_ptr_q +
                       ADDR_WIDTH'(count_q);
          idx_d      = 10'(count_q);
          count_d    = count_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d      = S_IDLE;
          fetch_ptr_d  = fetch_ptr_q + LINE_STEP;
          lines_done_d = lines_done_q + LW'(1);
        end else begin
          drain_d = 1'b1;
        end
      end
      S_WRITE: begin
        // Write went out on entry; the next IDLE
        // cycle ignores the still-held request.
        state_d  = S_IDLE;
        ignore_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      pending_d = 1'b1;
    end

    if (frame_start) begin
      fetch_ptr_d  = '0;
      lines_done_d = '0;
      pending_d    = line_req;
      if (state_q != S_WRITE) begin
        // Abort fetch/drain; in IDLE hold off any
        // new issue for this cycle.
        state_d    = S_IDLE;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        host_ack_d = 1'b0;
      end
    end
  end

  always_ff @(posedge buffer_clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_ptr_q  <= '0;
      lines_done_q <= '0;
      pending_q    <= 1'b0;
      count_q      <= '0;
      drain_q      <= 1'b0;
      ignore_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      idx_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_ptr_q  <= fetch_ptr_d;
      lines_done_q <= lines_done_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      drain_q      <= drain_d;
      ignore_q     <= ignore_d;
      host_ack_q   <= host_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      idx_q        <= idx_d;
      overrun_q    <= overrun_d;
    end
  end

  // Return path: strobe in cycle S, rdata in S+1,
  // registered pixel visible in S+2.
  always_ff @(posedge buffer_clock or posedge reset) begin
    if (reset) begin
      rd_v_q      <= 1'b0;
      rd_idx_q    <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      vid_index_q <= '0;
    end else begin
      rd_v_q      <= mem_en_q & ~mem_we_q;
      rd_idx_q    <= idx_q;
      vid_valid_q <= rd_v_q;
      if (rd_v_q) begin
        vid_data_q  <= mem_rdata;
        vid_index_q <= rd_idx_q;
      end
    end
  end

  assign host_ack  = host_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign vid_valid = vid_valid_q;
  assign vid_data  = vid_data_q;
  assign vid_index = vid_index_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Testbench for framebuffer_arbiter: vector table, directed corner
// sequences and randomized traffic checked by a scoreboard.
module tb_framebuffer_arbiter;

  localparam int AW = 22;
  localparam int DW = 12;
  localparam int LP = 640;
  localparam int LN = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          line_req = 1'b0;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic [9:0]    vid_index;
  logic          overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int rd_cnt = 0;
  bit chk_en = 1'b0;

  int exp_reads[$];
  int exp_vidx[$];
  int exp_vdat[$];
  int exp_waddr[$];
  int exp_wdata[$];
  int rd_t[$];

  typedef struct {
    logic hreq;
    logic lreq;
    logic ack;
    logic en;
    logic we;
    int   addr;
  } vec_t;

  vec_t tbl[7];

  framebuffer_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LINE_PIXELS(LP), .LINES(LN)
  ) dut (
    .buffer_clock(clk), .reset(reset),
    .frame_start(frame_start), .line_req(line_req),
    .host_req(host_req), .host_addr(host_addr),
    .host_data(host_data), .host_ack(host_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vid_valid(vid_valid),
    .vid_data(vid_data), .vid_index(vid_index),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pix(input int a);
    logic [AW-1:0] x;
    x = a[AW-1:0];
    return int'(x[11:0] ^ x[21:10] ^ 12'h5A5);
  endfunction

  // Memory model: read data valid exactly one cycle after strobe.
  always @(posedge clk) begin
    if (mem_en && !mem_we)
      mem_rdata <= DW'(pix(int'(mem_addr)));
    else
      mem_rdata <= DW'($urandom);
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input int act);
    total++;
    bad++;
    $display("FAIL %s: got 0x%0h expected none", nm, act);
  endtask

  task automatic expect_line(input int base, input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = (base + i) & ((1 << AW) - 1);
      exp_reads.push_back(a);
      exp_vidx.push_back(i);
      exp_vdat.push_back(pix(a));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_en && !mem_we) begin
        rd_cnt++;
        rd_t.push_back(cyc);
        if (exp_reads.size() == 0)
          flag("unexpected_read", int'(mem_addr));
        else
          chk("read_addr", int'(mem_addr),
              exp_reads.pop_front());
      end
      if (mem_en && mem_we) begin
        if (exp_waddr.size() == 0) begin
          flag("unexpected_write", int'(mem_addr));
        end else begin
          chk("write_addr", int'(mem_addr),
              exp_waddr.pop_front());
          chk("write_data", int'(mem_wdata),
              exp_wdata.pop_front());
        end
        chk("write_ack", int'(host_ack), 1);
      end else if (host_ack) begin
        flag("stray_ack", int'(host_ack));
      end
      if (vid_valid) begin
        if (exp_vidx.size() == 0) begin
          flag("unexpected_vid", int'(vid_index));
        end else begin
          chk("vid_index", int'(vid_index),
              exp_vidx.pop_front());
          chk("vid_data", int'(vid_data),
              exp_vdat.pop_front());
        end
        if (rd_t.size() != 0)
          chk("vid_latency", cyc - rd_t.pop_front(), 2);
      end
      if (overrun) ov_cnt++;
    end
  end

  task automatic pulse_line();
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_reads.size() != 0 ||
            exp_vidx.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reads_left", exp_reads.size(), 0);
    chk("vid_left", exp_vidx.size(), 0);
    exp_reads.delete();
    exp_vidx.delete();
    exp_vdat.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_ack && lat < 700);
    if (!host_ack) flag("ack_timeout", lat);
  endtask

  task automatic host_drv();
    int lat;
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(1, 80)) @(negedge clk);
      host_addr = AW'(32'h200000 |
                      $urandom_range(0, 32'h1FFFFF));
      host_data = DW'($urandom);
      exp_waddr.push_back(int'(host_addr));
      exp_wdata.push_back(int'(host_data));
      host_req = 1'b1;
      wait_ack(lat);
      host_req = 1'b0;
    end
  endtask

  task automatic line_drv();
    int n = 0;
    int w;
    pulse_frame();
    for (int k = 0; k < 10; k++) begin
      w = 0;
      while ((exp_reads.size() != 0 ||
              exp_vidx.size() != 0) && w < 2000) begin
        @(negedge clk);
        w++;
      end
      chk("rand_line_done", exp_vidx.size(), 0);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      if (n == LN) begin
        pulse_frame();
        n = 0;
      end
      expect_line(n * LP, LP);
      pulse_line();
      n++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rd0;
    int ov0;
    int n;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 'h1234};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", int'(host_ack), 0);
    chk("rst_en", int'(mem_en), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    chk("rst_vvalid", int'(vid_valid), 0);
    chk("rst_vdata", int'(vid_data), 0);
    chk("rst_vindex", int'(vid_index), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // vector table: host write, no double ack, then fetch start
    host_addr = AW'(32'h1234);
    host_data = DW'(12'hABC);
    exp_waddr.push_back('h1234);
    exp_wdata.push_back('hABC);
    expect_line(0, LP);
    for (int i = 0; i < 7; i++) begin
      host_req = tbl[i].hreq;
      line_req = tbl[i].lreq;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", i), int'(host_ack),
          int'(tbl[i].ack));
      chk($sformatf("tbl%0d_en", i), int'(mem_en),
          int'(tbl[i].en));
      chk($sformatf("tbl%0d_we", i), int'(mem_we),
          int'(tbl[i].we));
      if (tbl[i].en)
        chk($sformatf("tbl%0d_addr", i), int'(mem_addr),
            tbl[i].addr);
    end
    host_req = 1'b0;
    line_req = 1'b0;
    wait_drain(1500);

    // two sequential lines after frame_start
    pulse_frame();
    expect_line(0, LP);
    pulse_line();
    repeat (700) @(negedge clk);
    expect_line(LP, LP);
    pulse_line();
    wait_drain(1500);

    // simultaneous host_req + line_req: fetch first
    @(negedge clk);
    host_addr = AW'(32'h3ff00);
    host_data = DW'(12'h5C3);
    exp_waddr.push_back('h3ff00);
    exp_wdata.push_back('h5C3);
    expect_line(2 * LP, LP);
    host_req = 1'b1;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    wait_ack(lat);
    lat = lat + 1;
    chk("fetch_before_ack", exp_vidx.size(), 0);
    chk("ack_latency_ok", int'(lat <= 646), 1);
    host_req = 1'b0;
    wait_drain(100);

    // overrun: third line_req while pending
    pulse_frame();
    ov0 = ov_cnt;
    rd0 = rd_cnt;
    expect_line(0, LP);
    pulse_line();
    repeat (100) @(negedge clk);
    expect_line(LP, LP);
    pulse_line();
    repeat (5) @(negedge clk);
    pulse_line();
    wait_drain(3000);
    repeat (700) @(negedge clk);
    chk("overrun_pulses", ov_cnt - ov0, 1);
    chk("overrun_reads", rd_cnt - rd0, 2 * LP);

    // frame_start aborts line 5 at pixel 300
    pulse_frame();
    for (int k = 0; k < 4; k++) begin
      expect_line(k * LP, LP);
      pulse_line();
      wait_drain(1500);
    end
    rd0 = rd_cnt;
    expect_line(4 * LP, 300);
    pulse_line();
    n = 0;
    while (!(mem_en && !mem_we &&
             mem_addr == AW'(4 * LP + 299)) &&
           n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_point_seen", int'(n < 1000), 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("strobe_stop", int'(mem_en), 0);
    wait_drain(100);
    chk("aborted_reads", rd_cnt - rd0, 300);

    // refetch from 0, fill the frame, extra request ignored
    for (int k = 0; k < LN; k++) begin
      expect_line(k * LP, LP);
      pulse_line();
      wait_drain(1500);
    end
    rd0 = rd_cnt;
    pulse_line();
    repeat (700) @(negedge clk);
    chk("limit_ignored", rd_cnt - rd0, 0);
    pulse_frame();
    expect_line(0, LP);
    pulse_line();
    wait_drain(1500);

    // randomized traffic against the scoreboard
    fork
      host_drv();
      line_drv();
    join
    wait_drain(1500);
    chk("writes_left", exp_waddr.size(), 0);

    // reset mid-fetch drops outputs at once
    chk_en = 1'b0;
    pulse_frame();
    pulse_line();
    repeat (50) @(negedge clk);
    chk("busy_before_reset", int'(mem_en), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_en", int'(mem_en), 0);
    chk("mid_rst_addr", int'(mem_addr), 0);
    chk("mid_rst_vvalid", int'(vid_valid), 0);
    chk("mid_rst_vindex", int'(vid_index), 0);
    host_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_ack", int'(host_ack), 0);
    end
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
